// File: rtl/mem_map_pkg.sv
// Memory map and shared types for mem_responder.
// Holds region bases, MMIO register offsets, STATUS bit positions, the
// decoded-region enum and a helper that classifies a core byte address.
package mem_map_pkg;

  localparam logic [31:0] RAM_BASE   = 32'h0000_0000;
  localparam logic [31:0] MMIO_BASE  = 32'h8000_0000;

  localparam logic [31:0] CYCLE_OFS  = 32'h0000_0000;
  localparam logic [31:0] STATUS_OFS = 32'h0000_0004;
  localparam logic [31:0] TXDATA_OFS = 32'h0000_0008;

  localparam int unsigned ST_EMPTY     = 0;
  localparam int unsigned ST_FULL      = 1;
  localparam int unsigned ST_OVF       = 2;
  localparam int unsigned ST_COUNT_LSB = 8;

  typedef enum logic [2:0] {
    RegRam,
    RegCycle,
    RegStatus,
    RegTxdata,
    RegNone
  } region_e;

  // Byte-lane bits are ignored; MMIO registers need an exact word match.
  function automatic region_e decode_region(input logic [31:0] addr);
    logic [31:0] word_addr;
    word_addr = addr & ~32'h3;
    if (word_addr[31] == RAM_BASE[31]) return RegRam;
    case (word_addr)
      MMIO_BASE + CYCLE_OFS:  return RegCycle;
      MMIO_BASE + STATUS_OFS: return RegStatus;
      MMIO_BASE + TXDATA_OFS: return RegTxdata;
      default:                return RegNone;
    endcase
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Bus bundle between the core data port / TX peripheral and mem_responder.
//   MemWrite, ALUResult, WriteData : core -> responder (store strobe, address, data)
//   ReadData                       : responder -> core (combinational load data)
//   tx_data, tx_valid              : responder -> peripheral (FIFO head)
//   tx_ready                       : peripheral -> responder
// master = core + peripheral side, slave = the responder.
interface mem_responder_if;
  logic        MemWrite;
  logic [31:0] ALUResult;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  modport master (
    output MemWrite, ALUResult, WriteData, tx_ready,
    input  ReadData, tx_data, tx_valid
  );

  modport slave (
    input  MemWrite, ALUResult, WriteData, tx_ready,
    output ReadData, tx_data, tx_valid
  );
endinterface

// File: rtl/sync_fifo.sv
// Synchronous FIFO with combinational head output.
//   clk, reset : clock, async active-high reset (empties the FIFO)
//   push, din  : write request and data; accepted when not full or when popping
//   pop        : read request; ignored when empty
//   dout       : head entry, 0 while empty
//   empty, full, count : occupancy
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam logic [PtrW:0] FullCount = (PtrW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == FullCount);
  assign count = count_q;
  assign dout  = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    do_pop   = pop && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO still takes the push.
    do_push  = push && (!full || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; dout masks stale entries while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/mem_responder.sv
// Data-side memory responder for the single-cycle core.
//   clk, reset : clock, async active-high reset
//   bus        : core data port (MemWrite/ALUResult/WriteData/ReadData) and
//                TX peripheral handshake (tx_data/tx_valid/tx_ready)
// Holds the word RAM, the free-running CYCLE counter, the sticky OVF flag,
// the address decoder and the combinational read mux; TX bytes go through sync_fifo.
module mem_responder
  import mem_map_pkg::*;
#(
  parameter int unsigned RAM_WORDS  = 64,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input logic            clk,
  input logic            reset,
  mem_responder_if.slave bus
);

  localparam int unsigned IdxW = $clog2(RAM_WORDS);
  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

  region_e         region;
  logic [IdxW-1:0] ram_idx;
  logic [31:0]     ram_q [RAM_WORDS];
  logic [31:0]     cycle_q, cycle_d;
  logic            ovf_q, ovf_d;
  logic            push_req, pop;
  logic            fifo_empty, fifo_full;
  logic [CntW-1:0] fifo_count;
  logic [7:0]      fifo_dout;
  logic [31:0]     status;

  assign region  = decode_region(bus.ALUResult);
  // Upper RAM address bits are dropped, so the RAM aliases across the low half.
  assign ram_idx = bus.ALUResult[IdxW+1:2];

  assign push_req = bus.MemWrite && (region == RegTxdata);
  assign pop      = !fifo_empty && bus.tx_ready;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_req),
    .pop   (pop),
    .din   (bus.WriteData[7:0]),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_count)
  );

  assign bus.tx_valid = !fifo_empty;
  assign bus.tx_data  = fifo_dout;

  always_comb begin
    cycle_d = cycle_q + 32'd1;
    ovf_d   = ovf_q;
    // A dropped push outranks a W1C clear in the same cycle.
    if (push_req && fifo_full && !pop) begin
      ovf_d = 1'b1;
    end else if (bus.MemWrite && (region == RegStatus) && bus.WriteData[ST_OVF]) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      cycle_q <= cycle_d;
      ovf_q   <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (bus.MemWrite && (region == RegRam)) ram_q[ram_idx] <= bus.WriteData;
  end

  always_comb begin
    status                          = '0;
    status[ST_EMPTY]                = fifo_empty;
    status[ST_FULL]                 = fifo_full;
    status[ST_OVF]                  = ovf_q;
    status[ST_COUNT_LSB +: CntW]    = fifo_count;
  end

  always_comb begin
    bus.ReadData = '0;
    unique case (region)
      RegRam:    bus.ReadData = ram_q[ram_idx];
      RegCycle:  bus.ReadData = cycle_q;
      RegStatus: bus.ReadData = status;
      default:   bus.ReadData = '0;
    endcase
  end

endmodule
